// File: rtl/i2c_axi_target.sv
// I2C target that turns register writes/reads into AXI-lite transactions.
// SCL/SDA are oversampled on axi_clk; a 16-bit register address precedes 32-bit data.
`timescale 1ns/1ps
module i2c_axi_target #(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        axi_clk,
  input  logic        axi_rstn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic        wvalid,
  input  logic        wready,
  output logic [15:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  output logic        rd_timeout,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT_STOP
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_prev_q, sda_prev_q;
  logic scl_s, sda_s, scl_rise_s, scl_fall_s, start_s, stop_s, axi_idle_s;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  byte_q, byte_d;
  logic [7:0]  sh_q, sh_d, addr_hi_q, addr_hi_d;
  logic        rw_q, rw_d, ack_q, ack_d;
  logic [15:0] reg_addr_q, reg_addr_d, req_addr_q, req_addr_d;
  logic [23:0] wbuf_q, wbuf_d;
  logic [31:0] req_data_q, req_data_d, rd_sh_q, rd_sh_d;
  logic        wr_req_q, wr_req_d, rd_req_q, rd_req_d;
  logic        rd_live_q, rd_live_d, rd_got_q, rd_got_d;
  logic        sda_oe_q, sda_oe_d, busy_q, busy_d, rd_timeout_q, rd_timeout_d;
  logic [15:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;

  // Synchronize the bus lines and keep one previous sample for edge detection.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise_s = scl_s & ~scl_prev_q;
  assign scl_fall_s = ~scl_s & scl_prev_q;
  assign start_s    = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_s     = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign axi_idle_s = ~(awvalid_q | wvalid_q | arvalid_q | rready_q);

  // Next-state logic for the bus FSM and the AXI request/response side.
  always_comb begin
    state_d = state_q;      cnt_d = cnt_q;          byte_d = byte_q;
    sh_d = sh_q;            rw_d = rw_q;            ack_d = ack_q;
    addr_hi_d = addr_hi_q;  reg_addr_d = reg_addr_q; wbuf_d = wbuf_q;
    req_addr_d = req_addr_q; req_data_d = req_data_q;
    wr_req_d = wr_req_q;    rd_req_d = rd_req_q;    rd_live_d = rd_live_q;
    rd_got_d = rd_got_q;    rd_sh_d = rd_sh_q;
    sda_oe_d = sda_oe_q;    busy_d = busy_q;        rd_timeout_d = 1'b0;
    awaddr_d = awaddr_q;    wdata_d = wdata_q;      araddr_d = araddr_q;
    awvalid_d = awvalid_q & ~awready;
    wvalid_d  = wvalid_q & ~wready;
    arvalid_d = arvalid_q & ~arready;
    rready_d  = rready_q & ~rvalid;

    // Late read data (after the timeout substitution) completes the handshake but is dropped.
    if (rready_q && rvalid && rd_live_q) begin
      rd_sh_d  = rdata;
      rd_got_d = 1'b1;
    end else begin
      rd_got_d = rd_got_q;
    end

    if (axi_idle_s && wr_req_q) begin
      awaddr_d  = req_addr_q;
      wdata_d   = req_data_q;
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      wr_req_d  = 1'b0;
    end else if (axi_idle_s && rd_req_q) begin
      araddr_d  = reg_addr_q;
      arvalid_d = 1'b1;
      rready_d  = 1'b1;
      rd_req_d  = 1'b0;
      rd_live_d = 1'b1;
    end else begin
      rd_req_d  = rd_req_q;
    end

    if (stop_s) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_s) begin
      state_d  = DEV;
      cnt_d    = 4'd0;
      sda_oe_d = 1'b0;
    end else begin
      case (state_q)
        DEV, AHI, ALO, WDAT: begin
          if (scl_rise_s && (cnt_q != 4'd8)) begin
            sh_d  = {sh_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall_s && (cnt_q == 4'd8)) begin
            cnt_d    = 4'd0;
            sda_oe_d = 1'b1;
            case (state_q)
              DEV: begin
                if (sh_q[7:1] == DEV_ADDR) begin
                  state_d = DEV_ACK;
                  rw_d    = sh_q[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d  = WAIT_STOP;
                  sda_oe_d = 1'b0;
                end
              end
              AHI: begin
                addr_hi_d = sh_q;
                state_d   = AHI_ACK;
              end
              ALO: begin
                reg_addr_d = {addr_hi_q, sh_q};
                state_d    = ALO_ACK;
              end
              WDAT: begin
                if (byte_q == 3'd4) begin
                  state_d  = WAIT_STOP;
                  sda_oe_d = 1'b0;
                end else begin
                  byte_d  = byte_q + 3'd1;
                  wbuf_d  = {wbuf_q[15:0], sh_q};
                  state_d = WDAT_ACK;
                  if (byte_q == 3'd3) begin
                    wr_req_d   = 1'b1;
                    req_addr_d = reg_addr_q;
                    req_data_d = {wbuf_q, sh_q};
                  end else begin
                    wr_req_d   = wr_req_q;
                  end
                end
              end
              default: begin
                state_d  = IDLE;
                sda_oe_d = 1'b0;
              end
            endcase
          end else begin
            cnt_d = cnt_q;
          end
        end
        DEV_ACK: begin
          if (scl_rise_s && rw_q) begin
            rd_req_d = 1'b1;
            rd_got_d = 1'b0;
          end else if (scl_fall_s) begin
            byte_d = 3'd0;
            if (rw_q) begin
              rd_req_d  = 1'b0;
              rd_live_d = 1'b0;
              state_d   = RDAT;
              if (rd_got_q) begin
                sda_oe_d = ~rd_sh_q[31];
              end else begin
                rd_sh_d      = 32'hFFFF_FFFF;
                sda_oe_d     = 1'b0;
                rd_timeout_d = 1'b1;
              end
            end else begin
              sda_oe_d = 1'b0;
              state_d  = AHI;
            end
          end else begin
            state_d = DEV_ACK;
          end
        end
        AHI_ACK, ALO_ACK, WDAT_ACK: begin
          if (scl_fall_s) begin
            sda_oe_d = 1'b0;
            byte_d   = (state_q == ALO_ACK) ? 3'd0 : byte_q;
            state_d  = (state_q == AHI_ACK) ? ALO : WDAT;
          end else begin
            state_d = state_q;
          end
        end
        RDAT: begin
          if (scl_rise_s) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall_s) begin
            rd_sh_d = {rd_sh_q[30:0], 1'b1};
            if (cnt_q == 4'd8) begin
              cnt_d    = 4'd0;
              byte_d   = byte_q + 3'd1;
              sda_oe_d = 1'b0;
              state_d  = RDAT_ACK;
            end else begin
              sda_oe_d = ~rd_sh_q[30];
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        RDAT_ACK: begin
          if (scl_rise_s) begin
            ack_d = ~sda_s;
          end else if (scl_fall_s) begin
            if (ack_q && (byte_q != 3'd4)) begin
              state_d  = RDAT;
              sda_oe_d = ~rd_sh_q[31];
            end else begin
              state_d  = WAIT_STOP;
            end
          end else begin
            ack_d = ack_q;
          end
        end
        IDLE, WAIT_STOP: begin
          state_d = state_q;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge axi_clk or negedge axi_rstn) begin
    if (!axi_rstn) begin
      state_q <= IDLE;       cnt_q <= 4'd0;          byte_q <= 3'd0;
      sh_q <= 8'd0;          rw_q <= 1'b0;           ack_q <= 1'b0;
      addr_hi_q <= 8'd0;     reg_addr_q <= 16'd0;    wbuf_q <= 24'd0;
      req_addr_q <= 16'd0;   req_data_q <= 32'd0;
      wr_req_q <= 1'b0;      rd_req_q <= 1'b0;       rd_live_q <= 1'b0;
      rd_got_q <= 1'b0;      rd_sh_q <= 32'd0;
      sda_oe_q <= 1'b0;      busy_q <= 1'b0;         rd_timeout_q <= 1'b0;
      awaddr_q <= 16'd0;     wdata_q <= 32'd0;       araddr_q <= 16'd0;
      awvalid_q <= 1'b0;     wvalid_q <= 1'b0;
      arvalid_q <= 1'b0;     rready_q <= 1'b0;
    end else begin
      state_q <= state_d;    cnt_q <= cnt_d;         byte_q <= byte_d;
      sh_q <= sh_d;          rw_q <= rw_d;           ack_q <= ack_d;
      addr_hi_q <= addr_hi_d; reg_addr_q <= reg_addr_d; wbuf_q <= wbuf_d;
      req_addr_q <= req_addr_d; req_data_q <= req_data_d;
      wr_req_q <= wr_req_d;  rd_req_q <= rd_req_d;   rd_live_q <= rd_live_d;
      rd_got_q <= rd_got_d;  rd_sh_q <= rd_sh_d;
      sda_oe_q <= sda_oe_d;  busy_q <= busy_d;       rd_timeout_q <= rd_timeout_d;
      awaddr_q <= awaddr_d;  wdata_q <= wdata_d;     araddr_q <= araddr_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;
    end
  end

  assign sda_oe     = sda_oe_q;
  assign awaddr     = awaddr_q;
  assign awvalid    = awvalid_q;
  assign wdata      = wdata_q;
  assign wvalid     = wvalid_q;
  assign araddr     = araddr_q;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;
  assign rd_timeout = rd_timeout_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_axi_target.sv
// Directed bench: bit-banged I2C initiator plus a simple AXI-lite responder/monitor.
`timescale 1ns/1ps
module tb_i2c_axi_target;
  localparam int Q = 60;

  logic        axi_clk = 1'b0;
  logic        axi_rstn, scl, m_sda, sda_line;
  logic        sda_oe, awvalid, awready, wvalid, wready, arvalid, arready;
  logic        rvalid, rready, rd_timeout, busy;
  logic [15:0] awaddr, araddr;
  logic [31:0] wdata, rdata;

  int checks = 0, errors = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, tout_cnt = 0, split_cnt = 0, oe_cnt = 0, busy_cnt = 0;
  logic [15:0] aw_addr_seen = 16'd0, ar_addr_seen = 16'd0;
  logic [31:0] w_data_seen = 32'd0;
  int rd_delay = 0, rd_timer = 0;
  logic [31:0] rd_value = 32'd0;
  logic rd_pend = 1'b0, r_hs = 1'b0;

  assign sda_line = m_sda & ~sda_oe;
  always #5 axi_clk = ~axi_clk;

  i2c_axi_target dut (
    .axi_clk(axi_clk), .axi_rstn(axi_rstn), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .rd_timeout(rd_timeout), .busy(busy)
  );

  // Monitor handshakes and serve read data, all on the falling clock edge.
  initial begin
    rvalid = 1'b0;
    rdata  = 32'd0;
    forever begin
      @(negedge axi_clk);
      if (r_hs) begin rvalid = 1'b0; r_hs = 1'b0; end
      if (awvalid && awready) begin aw_cnt++; aw_addr_seen = awaddr; end
      if (wvalid && wready) begin w_cnt++; w_data_seen = wdata; end
      if (awvalid != wvalid) split_cnt++;
      if (sda_oe) oe_cnt++;
      if (busy) busy_cnt++;
      if (rd_timeout) tout_cnt++;
      if (arvalid && arready) begin
        ar_cnt++; ar_addr_seen = araddr; rd_pend = 1'b1; rd_timer = rd_delay;
      end else if (rd_pend) begin
        if (rd_timer == 0) begin rvalid = 1'b1; rdata = rd_value; rd_pend = 1'b0; end
        else rd_timer--;
      end
      if (rvalid && rready) r_hs = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic i2c_bit(input logic b, output logic r);
    m_sda = b; #(Q); scl = 1'b1; #(Q); r = sda_line; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_start();
    if (!scl) begin m_sda = 1'b1; #(Q); scl = 1'b1; #(Q); end
    m_sda = 1'b0; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; #(Q); scl = 1'b1; #(Q); m_sda = 1'b1; #(Q);
  endtask

  task automatic wbyte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) i2c_bit(d[i], r);
    i2c_bit(1'b1, r);
    ack = ~r;
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic r;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin i2c_bit(1'b1, r); d = {d[6:0], r}; end
    i2c_bit(nack, r);
  endtask

  task automatic wr_txn(input logic [15:0] ra, input logic [31:0] d, input int n, output int acks);
    logic a;
    logic [7:0] bt;
    i2c_start();
    wbyte(8'h54, a); acks = int'(a);
    wbyte(ra[15:8], a); acks += int'(a);
    wbyte(ra[7:0], a);  acks += int'(a);
    for (int i = 0; i < n; i++) begin
      bt = (i < 4) ? d[31-8*i -: 8] : 8'h99;
      wbyte(bt, a); acks += int'(a);
    end
    i2c_stop();
  endtask

  task automatic rd_txn(input logic last_nack, output logic [31:0] d, output int acks);
    logic a;
    logic [7:0] bt;
    i2c_start();
    wbyte(8'h55, a); acks = int'(a);
    d = 32'd0;
    for (int i = 0; i < 4; i++) begin
      rbyte((i == 3) ? last_nack : 1'b0, bt);
      d = {d[23:0], bt};
    end
  endtask

  initial begin
    int acks, b_aw, b_w, b_ar, b_oe, b_busy, b_tout, b_split;
    logic a, r;
    logic [7:0] bt;
    logic [31:0] got;
    axi_rstn = 1'b0; scl = 1'b1; m_sda = 1'b1;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    #23;
    check("rst_ctrl", {25'd0, sda_oe, awvalid, wvalid, arvalid, rready, rd_timeout, busy}, 32'd0);
    check("rst_addr", {awaddr, araddr}, 32'd0);
    check("rst_wdata", wdata, 32'd0);
    #20 axi_rstn = 1'b1;
    #100;

    // Full write of 0xDEADBEEF to register 0x0012.
    b_aw = aw_cnt; b_w = w_cnt; b_split = split_cnt; b_busy = busy_cnt;
    wr_txn(16'h0012, 32'hDEADBEEF, 4, acks);
    #200;
    check("wr_acks", acks, 32'd7);
    check("wr_aw_cnt", aw_cnt - b_aw, 32'd1);
    check("wr_w_cnt", w_cnt - b_w, 32'd1);
    check("wr_awaddr", {16'd0, aw_addr_seen}, 32'h0000_0012);
    check("wr_wdata", w_data_seen, 32'hDEADBEEF);
    check("wr_aw_w_together", split_cnt - b_split, 32'd0);
    check("wr_busy_seen", {31'd0, (busy_cnt - b_busy) > 0}, 32'd1);
    check("wr_busy_after_stop", {31'd0, busy}, 32'd0);

    // Set register 0x0034, repeated START, read four bytes.
    rd_value = 32'h12345678; rd_delay = 0; b_ar = ar_cnt; b_tout = tout_cnt;
    i2c_start();
    wbyte(8'h54, a); wbyte(8'h00, a); wbyte(8'h34, a);
    rd_txn(1'b0, got, acks);
    b_oe = oe_cnt;
    rbyte(1'b1, bt);
    i2c_stop();
    #200;
    check("rd_data", got, 32'h12345678);
    check("rd_dev_ack", acks, 32'd1);
    check("rd_araddr", {16'd0, ar_addr_seen}, 32'h0000_0034);
    check("rd_ar_cnt", ar_cnt - b_ar, 32'd1);
    check("rd_released_byte", {24'd0, bt}, 32'h0000_00FF);
    check("rd_released_oe", oe_cnt - b_oe, 32'd0);
    check("rd_no_timeout", tout_cnt - b_tout, 32'd0);

    // Wrong device address 0x2B.
    b_aw = aw_cnt; b_ar = ar_cnt; b_oe = oe_cnt; b_busy = busy_cnt;
    i2c_start();
    wbyte(8'h56, a); wbyte(8'h00, r);
    i2c_stop();
    #200;
    check("nm_ack", {31'd0, a}, 32'd0);
    check("nm_oe", oe_cnt - b_oe, 32'd0);
    check("nm_axi", (aw_cnt - b_aw) + (ar_cnt - b_ar), 32'd0);
    check("nm_busy", busy_cnt - b_busy, 32'd0);

    // Read with late rvalid: substitute all-ones, one timeout pulse.
    rd_delay = 300; b_ar = ar_cnt; b_tout = tout_cnt;
    rd_txn(1'b1, got, acks);
    i2c_stop();
    #4000;
    check("to_data", got, 32'hFFFF_FFFF);
    check("to_pulse", tout_cnt - b_tout, 32'd1);
    check("to_araddr", {16'd0, ar_addr_seen}, 32'h0000_0034);
    check("to_rready_done", {31'd0, rready}, 32'd0);
    rd_delay = 0;

    // Short write (2 data bytes) then a write with a 5th, NACKed byte.
    b_aw = aw_cnt;
    wr_txn(16'h0007, 32'hAABB_0000, 2, acks);
    #200;
    check("short_acks", acks, 32'd5);
    check("short_no_axi", aw_cnt - b_aw, 32'd0);
    b_aw = aw_cnt; b_w = w_cnt;
    wr_txn(16'h0001, 32'h0000_0005, 5, acks);
    #200;
    check("long_acks", acks, 32'd7);
    check("long_aw_cnt", (aw_cnt - b_aw) + (w_cnt - b_w), 32'd2);
    check("long_awaddr", {16'd0, aw_addr_seen}, 32'h0000_0001);
    check("long_wdata", w_data_seen, 32'h0000_0005);

    // Reset in the middle of data byte 3.
    b_aw = aw_cnt;
    i2c_start();
    wbyte(8'h54, a); wbyte(8'h00, a); wbyte(8'h02, a); wbyte(8'h11, a); wbyte(8'h22, a);
    for (int i = 7; i >= 4; i--) i2c_bit(1'b1, r);
    axi_rstn = 1'b0;
    #20;
    check("mid_rst_ctrl", {25'd0, sda_oe, awvalid, wvalid, arvalid, rready, rd_timeout, busy}, 32'd0);
    check("mid_rst_addr", {awaddr, araddr}, 32'd0);
    check("mid_rst_wdata", wdata, 32'd0);
    axi_rstn = 1'b1;
    b_oe = oe_cnt;
    for (int i = 3; i >= 0; i--) i2c_bit(1'b0, r);
    i2c_bit(1'b1, r);
    wbyte(8'h44, a);
    i2c_stop();
    #200;
    check("post_rst_ignore_oe", oe_cnt - b_oe, 32'd0);
    check("post_rst_no_axi", aw_cnt - b_aw, 32'd0);
    rd_value = 32'hA5C3_0F96; b_ar = ar_cnt;
    rd_txn(1'b1, got, acks);
    i2c_stop();
    #200;
    check("post_rst_rd_data", got, 32'hA5C3_0F96);
    check("post_rst_araddr", {16'd0, ar_addr_seen}, 32'h0000_0000);
    b_aw = aw_cnt;
    wr_txn(16'h0003, 32'h0102_0304, 4, acks);
    #200;
    check("post_rst_wr_acks", acks, 32'd7);
    check("post_rst_wr_cnt", aw_cnt - b_aw, 32'd1);
    check("post_rst_wr_addr", {16'd0, aw_addr_seen}, 32'h0000_0003);
    check("post_rst_wr_data", w_data_seen, 32'h0102_0304);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_axi_target.md
I2C_AXI_TARGET -- requirements
Module: i2c_axi_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h2A, the 7-bit I2C target address this block responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl_i/sda_i.
REQ-003 axi_clk  in  1  the only clock; SCL/SDA are sampled, never used as clocks.
REQ-004 axi_rstn  in  1  reset, asynchronous and active-low.
REQ-005 scl_i  in  1  I2C clock from the initiator, asynchronous.
REQ-006 sda_i  in  1  I2C data line, asynchronous.
REQ-007 sda_oe  out  1  open-drain pull-down enable; 1 drives SDA low, 0 releases it.
REQ-008 awaddr  out  16  AXI-lite write address; awvalid out 1; awready in 1.
REQ-009 wdata  out  32  AXI-lite write data; wvalid out 1; wready in 1.
REQ-010 araddr  out  16  AXI-lite read address; arvalid out 1; arready in 1.
REQ-011 rdata  in  32  AXI-lite read data; rvalid in 1; rready out 1.
REQ-012 rd_timeout  out  1  one-cycle pulse when read data was not available in time.
REQ-013 busy  out  1  high from a START with an address match until the following STOP.

Function
REQ-014 SHALL double-synchronize SCL/SDA and detect SCL rise/fall; START = SDA falls while SCL high; STOP = SDA rises while SCL high.
REQ-015 SHALL sample SDA on SCL rise and change sda_oe only on the axi_clk after SCL fall.
REQ-016 SHALL use FSM states IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, WAIT_STOP.
REQ-017 START in any state (including repeated START) -> DEV with the bit counter cleared; STOP in any state -> IDLE with sda_oe=0.
REQ-018 DEV: shift 8 bits MSB first; on match of [7:1] with DEV_ADDR, ACK (sda_oe=1 for the 9th SCL); on mismatch -> WAIT_STOP, no ACK.
REQ-019 R/W=0 -> AHI, then ALO; each byte is ACKed; the 16-bit register address is {AHI, ALO}.
REQ-020 WDAT: receive 4 bytes, first byte = wdata[31:24]; ACK each byte; a 5th or later byte is NACKed and the FSM -> WAIT_STOP.
REQ-021 On the 4th data byte complete, SHALL assert awvalid and wvalid together with the latched address/data; each valid is held until its own ready is seen; no B channel.
REQ-022 A write whose STOP arrives with fewer than 4 data bytes SHALL issue no AXI transaction.
REQ-023 R/W=1: on the DEV_ACK SCL rise, SHALL assert arvalid with araddr = last register address (reset 0), hold it until arready, and hold rready=1 until rvalid.
REQ-024 rdata SHALL be loaded into a 32-bit shift register on rvalid; if rvalid has not arrived by the SCL fall ending DEV_ACK, SHALL load 32'hFFFF_FFFF and pulse rd_timeout.
REQ-025 RDAT: drive bits MSB first (sda_oe = ~bit); release SDA in RDAT_ACK and sample the initiator ACK; ACK -> next byte; NACK -> WAIT_STOP.
REQ-026 After 4 read bytes, SHALL release SDA and ignore SCL until START/STOP; there is no address auto-increment.
REQ-027 While an AXI handshake is pending, a new START SHALL NOT drop valid; the next AXI request waits until the pending one completes.
REQ-028 Operation is guaranteed for axi_clk >= 8x SCL frequency; no clock stretching is performed.

Reset
REQ-029 axi_rstn low SHALL asynchronously force: FSM IDLE, sda_oe=0, awvalid=wvalid=arvalid=0, rready=0, rd_timeout=0, busy=0, awaddr=araddr=0, wdata=0, stored register address 0.
REQ-030 Reset release mid-transfer SHALL leave the block in IDLE, ignoring the bus until the next START.

Verification
REQ-031 Write 0x2A/reg 0x0012/data 0xDEADBEEF -> 7 ACKs, exactly one AW+W with awaddr=0x0012, wdata=0xDEADBEEF.
REQ-032 Read 0x2A/reg 0x0034 with AXI rdata=0x12345678 -> araddr=0x0034, SDA bytes 12,34,56,78, SDA released after the 4th initiator ACK.
REQ-033 Device address 0x2B -> sda_oe never asserted, no AXI activity, busy=0.
REQ-034 Read with rvalid delayed past DEV_ACK -> bytes FF,FF,FF,FF and one rd_timeout pulse.
REQ-035 Write with STOP after 2 data bytes -> no AXI write; the next full write to 0x0001 with 0x00000005 succeeds.
REQ-036 axi_rstn pulsed during WDAT byte 3 -> all outputs at reset values; the following complete transaction succeeds.
